// File: rtl/cache_tag_ctrl.sv
// Tag-array initiator for a 64-set x 4-way cache: clears the tag store after reset,
// looks up CPU requests, and sequences writeback/fill with memory on a miss.
package cache_def;
    typedef struct packed {
        logic [5:0] index;
        logic [1:0] way;
        logic       we;
    } cache_req_type;

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [19:0] tag;
    } cache_tag_type;
endpackage

module cache_tag_ctrl #(
    parameter int TAG_W    = 20,
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 6,
    parameter int WAYS     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req_valid,
    input  logic [31:0]             cpu_req_addr,
    input  logic                    cpu_req_rw,
    output logic                    cpu_req_ready,
    output logic                    cpu_resp_valid,
    output logic                    cpu_resp_hit,
    output logic [1:0]              cpu_resp_way,
    output cache_def::cache_req_type tag_req,
    output cache_def::cache_tag_type tag_write,
    input  cache_def::cache_tag_type tag_read [WAYS],
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [31:0]             mem_req_addr,
    input  logic                    mem_ack
);

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        IDLE      = 3'd1,
        COMPARE   = 3'd2,
        WRITEBACK = 3'd3,
        ALLOCATE  = 3'd4
    } state_t;

    state_t               state_r;
    logic [7:0]           init_cnt_r;
    logic [1:0]           rr_r;
    logic [TAG_W-1:0]     addr_tag_r;
    logic [INDEX_W-1:0]   index_r;
    logic                 rw_r;
    logic [1:0]           victim_r;
    logic [TAG_W-1:0]     victim_tag_r;
    logic                 victim_rr_r;

    logic                 hit_s;
    logic [1:0]           hit_way_s;
    logic                 inv_s;
    logic [1:0]           inv_way_s;
    logic [1:0]           victim_s;
    logic                 unused_offset_s;

    // Block offset never reaches the tag store or memory (addresses are block aligned).
    assign unused_offset_s = ^cpu_req_addr[OFFSET_W-1:0];

    // Tag compare and lowest-invalid search; scanning high-to-low lets the lowest way win.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = 2'd0;
        inv_s     = 1'b0;
        inv_way_s = 2'd0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (tag_read[i].valid && (tag_read[i].tag == addr_tag_r)) begin
                hit_s     = 1'b1;
                hit_way_s = 2'(i);
            end else begin
                hit_s     = hit_s;
            end
            if (!tag_read[i].valid) begin
                inv_s     = 1'b1;
                inv_way_s = 2'(i);
            end else begin
                inv_s     = inv_s;
            end
        end
        victim_s = inv_s ? inv_way_s : rr_r;
    end

    // Controller state machine and request/victim bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= INIT;
            init_cnt_r   <= 8'd0;
            rr_r         <= 2'd0;
            addr_tag_r   <= '0;
            index_r      <= '0;
            rw_r         <= 1'b0;
            victim_r     <= 2'd0;
            victim_tag_r <= '0;
            victim_rr_r  <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    init_cnt_r <= init_cnt_r + 8'd1;
                    if (init_cnt_r == 8'd255) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_tag_r <= cpu_req_addr[OFFSET_W+INDEX_W +: TAG_W];
                        index_r    <= cpu_req_addr[OFFSET_W +: INDEX_W];
                        rw_r       <= cpu_req_rw;
                        state_r    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        victim_r     <= victim_s;
                        victim_tag_r <= tag_read[victim_s].tag;
                        victim_rr_r  <= !inv_s;
                        if (tag_read[victim_s].valid && tag_read[victim_s].dirty) begin
                            state_r <= WRITEBACK;
                        end else begin
                            state_r <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        state_r <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        if (victim_rr_r) begin
                            rr_r <= rr_r + 2'd1;
                        end
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r    <= INIT;
                    init_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Output decode; everything is forced quiet while reset is asserted.
    always_comb begin
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_hit   = 1'b0;
        cpu_resp_way   = 2'd0;
        tag_req.index  = index_r;
        tag_req.way    = 2'd0;
        tag_req.we     = 1'b0;
        tag_write      = '0;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_addr   = 32'd0;
        if (!rst) begin
            case (state_r)
                INIT: begin
                    tag_req.index = init_cnt_r[7:2];
                    tag_req.way   = init_cnt_r[1:0];
                    tag_req.we    = 1'b1;
                end
                IDLE: begin
                    cpu_req_ready = 1'b1;
                end
                COMPARE: begin
                    if (hit_s) begin
                        cpu_resp_valid = 1'b1;
                        cpu_resp_hit   = 1'b1;
                        cpu_resp_way   = hit_way_s;
                        if (rw_r && !tag_read[hit_way_s].dirty) begin
                            tag_req.way     = hit_way_s;
                            tag_req.we      = 1'b1;
                            tag_write.valid = 1'b1;
                            tag_write.dirty = 1'b1;
                            tag_write.tag   = addr_tag_r;
                        end else begin
                            tag_req.we = 1'b0;
                        end
                    end else begin
                        cpu_resp_valid = 1'b0;
                    end
                end
                WRITEBACK: begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = 1'b1;
                    mem_req_addr  = {victim_tag_r, index_r, {OFFSET_W{1'b0}}};
                end
                ALLOCATE: begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = 1'b0;
                    mem_req_addr  = {addr_tag_r, index_r, {OFFSET_W{1'b0}}};
                    if (mem_ack) begin
                        tag_req.way     = victim_r;
                        tag_req.we      = 1'b1;
                        tag_write.valid = 1'b1;
                        tag_write.dirty = rw_r;
                        tag_write.tag   = addr_tag_r;
                        cpu_resp_valid  = 1'b1;
                        cpu_resp_hit    = 1'b0;
                        cpu_resp_way    = victim_r;
                    end else begin
                        cpu_resp_valid  = 1'b0;
                    end
                end
                default: begin
                    cpu_req_ready = 1'b0;
                end
            endcase
        end else begin
            cpu_req_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl: a behavioural tag store, queued expectations
// for CPU responses, tag writes and memory requests, and directed access sequences.
module tb_cache_tag_ctrl;
    import cache_def::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req_valid = 1'b0;
    logic [31:0]   cpu_req_addr = 32'd0;
    logic          cpu_req_rw = 1'b0;
    logic          cpu_req_ready;
    logic          cpu_resp_valid;
    logic          cpu_resp_hit;
    logic [1:0]    cpu_resp_way;
    cache_req_type tag_req;
    cache_tag_type tag_write;
    cache_tag_type tag_read [4];
    logic          mem_req_valid;
    logic          mem_req_rw;
    logic [31:0]   mem_req_addr;
    logic          mem_ack = 1'b0;

    cache_tag_type store [64][4];
    int            tests = 0;
    int            fails = 0;
    bit            init_done = 1'b0;
    logic [2:0]    resp_q [$];
    logic [29:0]   tw_q [$];
    logic [32:0]   mem_q [$];

    cache_tag_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_rw(cpu_req_rw),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_hit(cpu_resp_hit), .cpu_resp_way(cpu_resp_way),
        .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Tag store: combinational read, write on posedge.
    always_comb begin
        for (int w = 0; w < 4; w++) tag_read[w] = store[tag_req.index][w];
    end
    always @(posedge clk) begin
        if (tag_req.we) store[tag_req.index][tag_req.way] <= tag_write;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor.
    initial forever begin
        @(negedge clk); #2;
        if (cpu_resp_valid) begin
            if (resp_q.size() == 0) check("resp_unexpected", {61'd0, cpu_resp_hit, cpu_resp_way}, 64'h1ff);
            else check("resp", {61'd0, cpu_resp_hit, cpu_resp_way}, {61'd0, resp_q.pop_front()});
        end
    end

    // Tag write monitor (after the init sweep).
    initial forever begin
        @(negedge clk); #2;
        if (init_done && tag_req.we) begin
            if (tw_q.size() == 0) check("tagwr_unexpected", {34'd0, tag_req.index, tag_req.way, tag_write}, 64'hffff_ffff);
            else check("tagwr", {34'd0, tag_req.index, tag_req.way, tag_write}, {34'd0, tw_q.pop_front()});
        end
    end

    task automatic init_sweep();
        for (int k = 0; k < 256; k++) begin
            #1;
            check("init_step", {42'd0, tag_req.we, cpu_req_ready, tag_req.index, tag_req.way, tag_write},
                  {42'd0, 1'b1, 1'b0, 6'(k >> 2), 2'(k & 3), 22'd0});
            @(negedge clk);
        end
        #1 check("ready_after_init", {63'd0, cpu_req_ready}, 64'd1);
        init_done = 1'b1;
    endtask

    task automatic wait_ready();
        int cnt = 0;
        while (!cpu_req_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        if (!cpu_req_ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input logic [31:0] a, input logic rw, input logic exp_hit, input logic [1:0] exp_way);
        int cnt = 0;
        logic [32:0] exp_mem;
        wait_ready();
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_rw    = rw;
        resp_q.push_back({exp_hit, exp_way});
        @(negedge clk);
        cpu_req_valid = 1'b0;
        if (exp_hit) check("hit_latency", {63'd0, cpu_resp_valid}, 64'd1);
        while (!cpu_req_ready && cnt < 100) begin
            if (mem_req_valid) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", {31'd0, mem_req_rw, mem_req_addr}, 64'hffff_ffff_ffff);
                    exp_mem = 33'd0;
                end else begin
                    exp_mem = mem_q.pop_front();
                    check("mem_req", {31'd0, mem_req_rw, mem_req_addr}, {31'd0, exp_mem});
                end
                @(negedge clk);
                @(negedge clk);
                check("mem_hold", {30'd0, mem_req_valid, mem_req_rw, mem_req_addr}, {30'd0, 1'b1, exp_mem});
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
            cnt++;
        end
        if (!cpu_req_ready) check("req_timeout", 64'd0, 64'd1);
        check("mem_idle", {63'd0, mem_req_valid}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {58'd0, cpu_req_ready, cpu_resp_valid, mem_req_valid, tag_req.we, 2'd0}, 64'd0);
        rst = 1'b0;
        init_sweep();

        // Cold miss, then read hit and write hit on way 0.
        mem_q.push_back({1'b0, 32'h0001_5540});
        tw_q.push_back({6'h15, 2'd0, 1'b1, 1'b0, 20'h00015});
        do_req(32'h0001_5540, 1'b0, 1'b0, 2'd0);
        do_req(32'h0001_5540, 1'b0, 1'b1, 2'd0);
        tw_q.push_back({6'h15, 2'd0, 1'b1, 1'b1, 20'h00015});
        do_req(32'h0001_5540, 1'b1, 1'b1, 2'd0);

        // Fill ways 1..3 of set 0x15 with clean lines.
        for (int t = 1; t < 4; t++) begin
            mem_q.push_back({1'b0, 12'h000 + 20'(20'h00015 + t), 12'h540});
            tw_q.push_back({6'h15, 2'(t), 1'b1, 1'b0, 20'(20'h00015 + t)});
            do_req({20'(20'h00015 + t), 12'h540}, 1'b0, 1'b0, 2'(t));
        end

        // Set full: round-robin victim way 0 is dirty -> writeback then fill.
        mem_q.push_back({1'b1, 32'h0001_5540});
        mem_q.push_back({1'b0, 32'h000A_A540});
        tw_q.push_back({6'h15, 2'd0, 1'b1, 1'b0, 20'h000AA});
        do_req(32'h000A_A540, 1'b0, 1'b0, 2'd0);

        // Round-robin now 1: clean victim, fill only.
        mem_q.push_back({1'b0, 32'h000B_B540});
        tw_q.push_back({6'h15, 2'd1, 1'b1, 1'b0, 20'h000BB});
        do_req(32'h000B_B540, 1'b0, 1'b0, 2'd1);

        // Spurious mem_ack in IDLE must be ignored.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1 check("spurious_ack", {62'd0, cpu_req_ready, mem_req_valid}, 64'd2);
        do_req(32'h000B_B540, 1'b0, 1'b1, 2'd1);
        tw_q.push_back({6'h15, 2'd0, 1'b1, 1'b1, 20'h000AA});
        do_req(32'h000A_A540, 1'b1, 1'b1, 2'd0);

        // Top index, write miss allocates a dirty line.
        mem_q.push_back({1'b0, 32'h1234_5FC0});
        tw_q.push_back({6'h3F, 2'd0, 1'b1, 1'b1, 20'h12345});
        do_req(32'h1234_5FC0, 1'b1, 1'b0, 2'd0);

        // Dirty way 2, then miss so round-robin (2) forces a writeback, and reset mid-writeback.
        tw_q.push_back({6'h15, 2'd2, 1'b1, 1'b1, 20'h00017});
        do_req(32'h0001_7540, 1'b1, 1'b1, 2'd2);
        wait_ready();
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h000C_C540;
        cpu_req_rw    = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        begin
            int cnt = 0;
            while (!mem_req_valid && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
        end
        check("wb_req", {30'd0, mem_req_valid, mem_req_rw, mem_req_addr}, {30'd0, 1'b1, 1'b1, 32'h0001_7540});
        @(negedge clk);
        init_done = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort", {62'd0, mem_req_valid, cpu_resp_valid}, 64'd0);
        rst = 1'b0;
        init_sweep();

        // Store was cleared: former line is a miss again.
        mem_q.push_back({1'b0, 32'h0001_5540});
        tw_q.push_back({6'h15, 2'd0, 1'b1, 1'b0, 20'h00015});
        do_req(32'h0001_5540, 1'b0, 1'b0, 2'd0);

        repeat (3) @(negedge clk);
        check("queues_drained", {32'd0, 16'(resp_q.size()), 8'(tw_q.size()), 8'(mem_q.size())}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
